// File: rtl/msx_pkg.sv
// Shared types and constants for the msxbus slave-bridge cycle scheduler.
package msx_pkg;

    localparam int MSX_AW = 16;
    localparam int MSX_DW = 8;

    // Bus-cycle sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        RECOV = 2'd3
    } msx_state_e;

    // Saturating increment for the 8-bit phase and timeout counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msx_rr_arb2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time is favoured.
module msx_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr_r;
    logic [1:0] gnt_s;

    // Grant the lone requester, or the port other than rr_ptr when both request.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = rr_ptr_r ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    // Remember the winner of a contended grant; uncontended grants leave the pointer alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            rr_ptr_r <= gnt_s[1];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/msx_cycle_sched.sv
// Two-port msxbus cycle scheduler: arbitrates host/DMA and sequences address, data and recovery phases.
module msx_cycle_sched
    import msx_pkg::*;
#(
    parameter int ADDR_CYC  = 2,
    parameter int DATA_CYC  = 4,
    parameter int RECOV_CYC = 1,
    parameter int TMO_CYC   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [MSX_AW-1:0] addr0,
    input  logic [MSX_AW-1:0] addr1,
    input  logic [MSX_DW-1:0] wdata0,
    input  logic [MSX_DW-1:0] wdata1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic              mio0,
    input  logic              mio1,
    input  logic              slot0,
    input  logic              slot1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [MSX_DW-1:0] rdata,
    output logic              busy,
    output logic              cs,
    output logic              a0,
    output logic              mode,
    output logic              mio,
    output logic              rw,
    output logic              sltsl,
    output logic [15:0]       md_out,
    output logic              md_oe,
    input  logic [15:0]       md_in,
    input  logic              wait_n
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_CYC - 1);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_CYC - 1);
    localparam logic [7:0] RECOV_LAST = 8'(RECOV_CYC - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TMO_CYC);

    msx_state_e        state_r, state_nx;
    logic [7:0]        ph_cnt_r, ph_cnt_nx;
    logic [7:0]        tmo_cnt_r, tmo_cnt_nx;
    logic [1:0]        gnt_s;
    logic              grant_s, exit_s;
    logic              port_r, rd_r, mio_r, slot_r;
    logic [MSX_AW-1:0] addr_r;
    logic [MSX_DW-1:0] wdata_r;
    logic              cs_r, cs_nx, a0_r, a0_nx, md_oe_r, md_oe_nx, busy_r, busy_nx;
    logic [15:0]       md_out_r, md_out_nx;
    logic [MSX_DW-1:0] rdata_r, rdata_nx;
    logic [1:0]        ack_r, ack_nx, err_r, err_nx;
    logic              unused_md_hi_s;

    // Only the low byte of md carries read data.
    assign unused_md_hi_s = ^md_in[15:8];

    msx_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1, req0}),
        .advance (grant_s),
        .gnt     (gnt_s)
    );

    // Next-state and next-output logic for the phase sequencer.
    always_comb begin
        state_nx   = state_r;
        ph_cnt_nx  = ph_cnt_r;
        tmo_cnt_nx = tmo_cnt_r;
        cs_nx      = cs_r;
        a0_nx      = a0_r;
        md_oe_nx   = md_oe_r;
        md_out_nx  = md_out_r;
        busy_nx    = busy_r;
        rdata_nx   = rdata_r;
        ack_nx     = 2'b00;
        err_nx     = 2'b00;
        grant_s    = 1'b0;
        exit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_s != 2'b00) begin
                    grant_s   = 1'b1;
                    state_nx  = ADDR;
                    ph_cnt_nx = 8'd0;
                    cs_nx     = 1'b0;
                    a0_nx     = 1'b0;
                    md_oe_nx  = 1'b1;
                    md_out_nx = gnt_s[1] ? addr1 : addr0;
                    busy_nx   = 1'b1;
                end else begin
                    cs_nx    = 1'b1;
                    a0_nx    = 1'b0;
                    md_oe_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            end
            ADDR: begin
                if (ph_cnt_r >= ADDR_LAST) begin
                    state_nx   = DATA;
                    ph_cnt_nx  = 8'd0;
                    tmo_cnt_nx = 8'd0;
                    a0_nx      = 1'b1;
                    if (rd_r) begin
                        md_oe_nx = 1'b0;
                    end else begin
                        md_oe_nx  = 1'b1;
                        md_out_nx = {8'h00, wdata_r};
                    end
                end else begin
                    ph_cnt_nx = sat_inc8(ph_cnt_r);
                end
            end
            DATA: begin
                if (ph_cnt_r < DATA_LAST) begin
                    ph_cnt_nx = sat_inc8(ph_cnt_r);
                end else if (wait_n) begin
                    exit_s = 1'b1;
                    ack_nx = port_r ? 2'b10 : 2'b01;
                    if (rd_r) begin
                        rdata_nx = md_in[7:0];
                    end else begin
                        rdata_nx = rdata_r;
                    end
                end else if (tmo_cnt_r >= TMO_LAST) begin
                    exit_s = 1'b1;
                    err_nx = port_r ? 2'b10 : 2'b01;
                end else begin
                    tmo_cnt_nx = sat_inc8(tmo_cnt_r);
                end
                if (exit_s) begin
                    state_nx  = RECOV;
                    ph_cnt_nx = 8'd0;
                    cs_nx     = 1'b1;
                    md_oe_nx  = 1'b0;
                    a0_nx     = 1'b0;
                end else begin
                    state_nx = DATA;
                end
            end
            RECOV: begin
                if (ph_cnt_r >= RECOV_LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    ph_cnt_nx = sat_inc8(ph_cnt_r);
                end
            end
            default: begin
                state_nx = IDLE;
                cs_nx    = 1'b1;
                a0_nx    = 1'b0;
                md_oe_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State register and phase/timeout counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ph_cnt_r  <= 8'd0;
            tmo_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nx;
            ph_cnt_r  <= ph_cnt_nx;
            tmo_cnt_r <= tmo_cnt_nx;
        end
    end

    // Capture the granted port's request so later input changes cannot disturb the cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_r  <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 8'h00;
            rd_r    <= 1'b1;
            mio_r   <= 1'b1;
            slot_r  <= 1'b1;
        end else if (grant_s) begin
            port_r  <= gnt_s[1];
            addr_r  <= gnt_s[1] ? addr1  : addr0;
            wdata_r <= gnt_s[1] ? wdata1 : wdata0;
            rd_r    <= gnt_s[1] ? rw1    : rw0;
            mio_r   <= gnt_s[1] ? mio1   : mio0;
            slot_r  <= gnt_s[1] ? slot1  : slot0;
        end else begin
            port_r  <= port_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            rd_r    <= rd_r;
            mio_r   <= mio_r;
            slot_r  <= slot_r;
        end
    end

    // Registered bridge strobes, md bus drive, read data and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_r     <= 1'b1;
            a0_r     <= 1'b0;
            md_oe_r  <= 1'b0;
            md_out_r <= 16'h0000;
            busy_r   <= 1'b0;
            rdata_r  <= 8'h00;
            ack_r    <= 2'b00;
            err_r    <= 2'b00;
        end else begin
            cs_r     <= cs_nx;
            a0_r     <= a0_nx;
            md_oe_r  <= md_oe_nx;
            md_out_r <= md_out_nx;
            busy_r   <= busy_nx;
            rdata_r  <= rdata_nx;
            ack_r    <= ack_nx;
            err_r    <= err_nx;
        end
    end

    assign cs     = cs_r;
    assign a0     = a0_r;
    assign md_oe  = md_oe_r;
    assign md_out = md_out_r;
    assign busy   = busy_r;
    assign rdata  = rdata_r;
    assign ack0   = ack_r[0];
    assign ack1   = ack_r[1];
    assign err0   = err_r[0];
    assign err1   = err_r[1];
    assign mio    = mio_r;
    assign rw     = rd_r;
    assign sltsl  = slot_r;
    assign mode   = 1'b0;

endmodule

// File: tb/tb_msx_cycle_sched.sv
// Self-checking bench for msx_cycle_sched: directed cases plus randomized transactions
// compared against a transaction-level timing model.
module tb_msx_cycle_sched;

    localparam int ADDR_CYC  = 2;
    localparam int DATA_CYC  = 4;
    localparam int RECOV_CYC = 1;
    localparam int TMO_CYC   = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        rw0, rw1, mio0, mio1, slot0, slot1;
    logic        ack0, ack1, err0, err1;
    logic [7:0]  rdata;
    logic        busy, cs, a0, mode, mio, rw, sltsl, md_oe;
    logic [15:0] md_out, md_in;
    logic        wait_n;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: round-robin pointer and last returned read byte.
    bit         rr_ptr_m;
    logic [7:0] rdata_m;

    always #5 clk = ~clk;

    msx_cycle_sched #(
        .ADDR_CYC (ADDR_CYC),
        .DATA_CYC (DATA_CYC),
        .RECOV_CYC(RECOV_CYC),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .rw0(rw0), .rw1(rw1),
        .mio0(mio0), .mio1(mio1),
        .slot0(slot0), .slot1(slot1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy), .cs(cs), .a0(a0), .mode(mode),
        .mio(mio), .rw(rw), .sltsl(sltsl),
        .md_out(md_out), .md_oe(md_oe), .md_in(md_in), .wait_n(wait_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one transaction from IDLE. w_lows = consecutive wait_n=0 samples once the minimum
    // data phase has elapsed; more than TMO_CYC means the cycle must time out.
    task automatic serve(input int w_lows, input bit drop_req);
        int         win;
        int         ext;
        int         cs_low;
        bit         tmo;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic        e_rd, e_mio, e_slot;
        logic [3:0]  e_done;
        if (req0 && req1) begin
            win      = rr_ptr_m ? 0 : 1;
            rr_ptr_m = (win == 1);
        end else begin
            win = req1 ? 1 : 0;
        end
        e_addr = win ? addr1  : addr0;
        e_wd   = win ? wdata1 : wdata0;
        e_rd   = win ? rw1    : rw0;
        e_mio  = win ? mio1   : mio0;
        e_slot = win ? slot1  : slot0;
        tmo    = (w_lows > TMO_CYC);
        ext    = tmo ? TMO_CYC : w_lows;
        cs_low = ADDR_CYC + DATA_CYC + ext;
        tick();
        for (int t = 1; t <= cs_low; t++) begin
            chk("cs_low", cs, 1'b0);
            chk("busy_hi", busy, 1'b1);
            chk("a0_phase", a0, (t > ADDR_CYC) ? 1'b1 : 1'b0);
            chk("md_oe", md_oe, (t <= ADDR_CYC) ? 1'b1 : !e_rd);
            if (t <= ADDR_CYC) begin
                chk("md_out_addr", md_out, e_addr);
            end else if (!e_rd) begin
                chk("md_out_wdata", md_out, {8'h00, e_wd});
            end
            chk("no_done_early", {err1, err0, ack1, ack0}, 4'b0000);
            chk("mio_latched", mio, e_mio);
            chk("rw_latched", rw, e_rd);
            chk("sltsl_latched", sltsl, e_slot);
            if (t == 1) begin
                if (win == 1) begin
                    addr1 = 16'($urandom); wdata1 = 8'($urandom);
                end else begin
                    addr0 = 16'($urandom); wdata0 = 8'($urandom);
                end
            end
            if (t == 2 && drop_req) begin
                if (win == 1) req1 = 1'b0; else req0 = 1'b0;
            end
            if (t == ADDR_CYC + DATA_CYC && w_lows > 0) wait_n = 1'b0;
            if (!tmo && w_lows > 0 && t == cs_low) wait_n = 1'b1;
            tick();
        end
        if (tmo) e_done = win ? 4'b1000 : 4'b0100;
        else     e_done = win ? 4'b0010 : 4'b0001;
        if (!tmo && e_rd) rdata_m = md_in[7:0];
        chk("done_pulse", {err1, err0, ack1, ack0}, e_done);
        chk("rdata", rdata, rdata_m);
        chk("cs_recov", cs, 1'b1);
        chk("md_oe_recov", md_oe, 1'b0);
        chk("busy_recov", busy, 1'b1);
        if (win == 1) req1 = 1'b0; else req0 = 1'b0;
        wait_n = 1'b1;
        tick();
        chk("done_one_cycle", {err1, err0, ack1, ack0}, 4'b0000);
        chk("busy_idle", busy, 1'b0);
        chk("cs_idle", cs, 1'b1);
        chk("rdata_held", rdata, rdata_m);
    endtask

    task automatic rand_port(input int p);
        if (p == 1) begin
            addr1 = 16'($urandom); wdata1 = 8'($urandom);
            rw1 = 1'($urandom); mio1 = 1'($urandom); slot1 = 1'($urandom);
        end else begin
            addr0 = 16'($urandom); wdata0 = 8'($urandom);
            rw0 = 1'($urandom); mio0 = 1'($urandom); slot0 = 1'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wait_n = 1'b1; md_in = 16'h0000;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0;
        rw0 = 1'b1; rw1 = 1'b1; mio0 = 1'b1; mio1 = 1'b1; slot0 = 1'b1; slot1 = 1'b1;
        rr_ptr_m = 1'b0; rdata_m = 8'h00;

        // Reset values.
        tick(); tick();
        chk("rst_cs", cs, 1'b1);
        chk("rst_a0", a0, 1'b0);
        chk("rst_md_oe", md_oe, 1'b0);
        chk("rst_md_out", md_out, 16'h0000);
        chk("rst_mio", mio, 1'b1);
        chk("rst_rw", rw, 1'b1);
        chk("rst_sltsl", sltsl, 1'b1);
        chk("rst_mode", mode, 1'b0);
        chk("rst_done", {err1, err0, ack1, ack0}, 4'b0000);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Port 0 memory write to 4000h.
        addr0 = 16'h4000; wdata0 = 8'hA5; rw0 = 1'b0; mio0 = 1'b0; slot0 = 1'b1; req0 = 1'b1;
        serve(0, 1'b0);

        // Port 1 I/O read from 98h.
        addr1 = 16'h0098; rw1 = 1'b1; mio1 = 1'b1; slot1 = 1'b0; md_in = 16'hC33C; req1 = 1'b1;
        serve(0, 1'b0);

        // Simultaneous requests, twice: order must alternate.
        for (int r = 0; r < 2; r++) begin
            rand_port(0); rand_port(1); md_in = 16'($urandom);
            req0 = 1'b1; req1 = 1'b1;
            serve(0, 1'b0);
            serve(0, 1'b0);
        end

        // WAIT stretches by exactly 10 clocks; then the boundary just below timeout; then timeout.
        addr0 = 16'h4000; wdata0 = 8'hA5; rw0 = 1'b0; mio0 = 1'b0; slot0 = 1'b1; req0 = 1'b1;
        serve(10, 1'b0);
        rw0 = 1'b1; md_in = 16'h005A; req0 = 1'b1;
        serve(TMO_CYC, 1'b0);
        md_in = 16'h00EE; req0 = 1'b1;
        serve(TMO_CYC + 50, 1'b0);

        // Reset during the data phase aborts the cycle without a completion pulse.
        rand_port(0); req0 = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mid_a0", a0, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_cs", cs, 1'b1);
        chk("abort_md_oe", md_oe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", {err1, err0, ack1, ack0}, 4'b0000);
        req0 = 1'b0; rst_n = 1'b1; rr_ptr_m = 1'b0; rdata_m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_no_ack", {err1, err0, ack1, ack0}, 4'b0000);
            chk("abort_idle_cs", cs, 1'b1);
        end
        rand_port(1); md_in = 16'($urandom); req1 = 1'b1;
        serve(0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 30; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_port(0); rand_port(1); md_in = 16'($urandom);
            req0 = pat[0]; req1 = pat[1];
            serve(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, 1'($urandom));
            if (pat == 3) begin
                md_in = 16'($urandom);
                serve(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
